// File: rtl/opfetch.sv
// opfetch -- operand-fetch stage between decode and execute.
//
// Accepts one decoded instruction per cycle (i_valid/o_ready), drives the
// register-file read indices combinationally, and captures opcode, operands
// and destination info into a one-entry output register (o_valid/i_ready).
// A 32-bit pending-write scoreboard stalls read-after-write hazards.
//
// Optional feature macro: OPF_FWD_EN
//   defined   -> writeback value bypasses into operand select and clears the
//                hazard in the same cycle it is written back.
//   undefined -> no bypass; any nonzero pending source stalls, i_wb_val unused.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_valid / o_ready             decode-side handshake
//   i_op, i_rs0, i_rs1, i_rd,
//   i_rd_we, i_imm                decoded instruction fields
//   o_reg0, o_reg1                register-file read indices
//   i_reg0_val, i_reg1_val        register-file read data (same cycle)
//   i_wb_en, i_wb_reg, i_wb_val   writeback commit
//   o_valid / i_ready             execute-side handshake
//   o_op, o_a, o_b, o_rd,
//   o_rd_we, o_imm                registered instruction and operands
//   o_stalls                      saturating hazard-stall cycle count
module opfetch (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs0,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_we,
  input  logic [31:0] i_imm,
  output logic [4:0]  o_reg0,
  output logic [4:0]  o_reg1,
  input  logic [31:0] i_reg0_val,
  input  logic [31:0] i_reg1_val,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_reg,
  input  logic [31:0] i_wb_val,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [5:0]  o_op,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic [31:0] o_imm,
  output logic [15:0] o_stalls
);

  logic [31:0] r_pend;
  logic [31:0] w_pend_nxt;
  logic        r_valid;
  logic [5:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic [31:0] r_imm;
  logic [15:0] r_stalls;

  logic        w_byp0;
  logic        w_byp1;
  logic        w_hz0;
  logic        w_hz1;
  logic        w_hazard;
  logic        w_issue;
  logic [31:0] w_a;
  logic [31:0] w_b;

`ifdef OPF_FWD_EN
  assign w_byp0 = i_wb_en && (i_wb_reg == i_rs0);
  assign w_byp1 = i_wb_en && (i_wb_reg == i_rs1);
`else
  logic w_unused_wb_val;
  assign w_byp0          = 1'b0;
  assign w_byp1          = 1'b0;
  assign w_unused_wb_val = ^i_wb_val;
`endif

  assign o_reg0 = i_rs0;
  assign o_reg1 = i_rs1;

  assign w_hz0    = (i_rs0 != '0) && r_pend[i_rs0] && !w_byp0;
  assign w_hz1    = (i_rs1 != '0) && r_pend[i_rs1] && !w_byp1;
  assign w_hazard = i_valid && (w_hz0 || w_hz1);
  assign o_ready  = (!r_valid || i_ready) && !w_hazard;
  assign w_issue  = i_valid && o_ready;

  always_comb begin
    w_a = i_reg0_val;
    w_b = i_reg1_val;
`ifdef OPF_FWD_EN
    if (w_byp0) w_a = i_wb_val;
    if (w_byp1) w_b = i_wb_val;
`endif
    if (i_rs0 == '0) w_a = '0;
    if (i_rs1 == '0) w_b = '0;
  end

  // Clear before set: a same-cycle issue to the written-back register belongs
  // to a younger writer, so its pending bit must survive.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_wb_en) w_pend_nxt[i_wb_reg] = 1'b0;
    if (w_issue && i_rd_we && (i_rd != '0)) w_pend_nxt[i_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend   <= '0;
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_rd_we  <= 1'b0;
      r_imm    <= '0;
      r_stalls <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_issue) begin
        r_valid <= 1'b1;
        r_op    <= i_op;
        r_a     <= w_a;
        r_b     <= w_b;
        r_rd    <= i_rd;
        r_rd_we <= i_rd_we;
        r_imm   <= i_imm;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_hazard && (r_stalls != '1)) r_stalls <= r_stalls + 16'd1;
    end
  end

  assign o_valid  = r_valid;
  assign o_op     = r_op;
  assign o_a      = r_a;
  assign o_b      = r_b;
  assign o_rd     = r_rd;
  assign o_rd_we  = r_rd_we;
  assign o_imm    = r_imm;
  assign o_stalls = r_stalls;

endmodule

// File: tb/tb_opfetch.sv
// Testbench for opfetch: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model (pending-register
// array, held-instruction record, stall counter).
module tb_opfetch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_op;
  logic [4:0]  i_rs0, i_rs1, i_rd;
  logic        i_rd_we;
  logic [31:0] i_imm;
  logic [4:0]  o_reg0, o_reg1;
  logic [31:0] i_reg0_val, i_reg1_val;
  logic        i_wb_en;
  logic [4:0]  i_wb_reg;
  logic [31:0] i_wb_val;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_op;
  logic [31:0] o_a, o_b;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic [31:0] o_imm;
  logic [15:0] o_stalls;

  opfetch dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs0(i_rs0), .i_rs1(i_rs1), .i_rd(i_rd), .i_rd_we(i_rd_we),
    .i_imm(i_imm), .o_reg0(o_reg0), .o_reg1(o_reg1),
    .i_reg0_val(i_reg0_val), .i_reg1_val(i_reg1_val),
    .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
    .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op), .o_a(o_a), .o_b(o_b),
    .o_rd(o_rd), .o_rd_we(o_rd_we), .o_imm(o_imm), .o_stalls(o_stalls)
  );

  always #5 i_clk = ~i_clk;

`ifdef OPF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Reference model state
  bit          pend [32];
  bit          m_ov;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic        m_we;
  int unsigned m_stalls;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (pend[k]) pend[k] = 1'b0;
    m_ov = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0;
    m_rd = '0; m_we = 1'b0; m_stalls = 0;
  endtask

  function automatic bit blocked(input logic [4:0] idx);
    bit fwd_hit;
    fwd_hit = FWD && i_wb_en && (i_wb_reg == idx);
    return (idx != 0) && pend[idx] && !fwd_hit;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (FWD && i_wb_en && (i_wb_reg == idx)) return i_wb_val;
    return rf;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, m_ov});
    chk({tag, ".o_op"}, {26'd0, o_op}, {26'd0, m_op});
    chk({tag, ".o_a"}, o_a, m_a);
    chk({tag, ".o_b"}, o_b, m_b);
    chk({tag, ".o_rd"}, {27'd0, o_rd}, {27'd0, m_rd});
    chk({tag, ".o_rd_we"}, {31'd0, o_rd_we}, {31'd0, m_we});
    chk({tag, ".o_imm"}, o_imm, m_imm);
    chk({tag, ".o_stalls"}, {16'd0, o_stalls}, m_stalls);
  endtask

  // One clock: check combinational outputs, advance model at the edge,
  // then check registered outputs. Called at posedge+1 with inputs driven.
  task automatic cycle(input string tag, input bit do_chk);
    bit hz, rdy, iss;
    #1;
    hz  = i_valid && (blocked(i_rs0) || blocked(i_rs1));
    rdy = (!m_ov || i_ready) && !hz;
    iss = i_valid && rdy;
    if (do_chk) begin
      chk({tag, ".o_ready"}, {31'd0, o_ready}, {31'd0, rdy});
      chk({tag, ".o_reg0"}, {27'd0, o_reg0}, {27'd0, i_rs0});
      chk({tag, ".o_reg1"}, {27'd0, o_reg1}, {27'd0, i_rs1});
    end
    @(posedge i_clk);
    if (iss) begin
      m_ov = 1'b1; m_op = i_op; m_rd = i_rd; m_we = i_rd_we; m_imm = i_imm;
      m_a = operand(i_rs0, i_reg0_val);
      m_b = operand(i_rs1, i_reg1_val);
    end else if (i_ready) begin
      m_ov = 1'b0;
    end
    if (i_wb_en) pend[i_wb_reg] = 1'b0;
    if (iss && i_rd_we && i_rd != 0) pend[i_rd] = 1'b1;
    if (hz && m_stalls < 32'hFFFF) m_stalls++;
    #1;
    if (do_chk) check_regs(tag);
  endtask

  task automatic instr(input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic we);
    i_valid = 1'b1; i_op = 6'($urandom); i_imm = $urandom;
    i_rs0 = rs0; i_rs1 = rs1; i_rd = rd; i_rd_we = we;
    i_reg0_val = $urandom; i_reg1_val = $urandom;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    i_op = '0; i_rs0 = 5'd1; i_rs1 = 5'd2; i_rd = 5'd3; i_rd_we = 1'b1; i_imm = '0;
    i_reg0_val = '0; i_reg1_val = '0; i_wb_en = 1'b0; i_wb_reg = '0; i_wb_val = '0;
    model_reset();

    // Reset held with i_valid asserted
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst.o_stalls", {16'd0, o_stalls}, 32'd0);
    chk("rst.o_ready", {31'd0, o_ready}, 32'd1);
    check_regs("rst");
    i_rst = 1'b0;

    // First issue: rs0=3 reads 0x11
    instr(5'd3, 5'd0, 5'd0, 1'b0);
    i_reg0_val = 32'h11;
    cycle("first", 1'b1);
    chk("first.o_a_11", o_a, 32'h11);
    chk("first.o_valid_1", {31'd0, o_valid}, 32'd1);

    // Back-to-back RAW on r5
    instr(5'd1, 5'd2, 5'd5, 1'b1);
    cycle("raw_w", 1'b1);
    instr(5'd5, 5'd0, 5'd6, 1'b0);
    i_reg0_val = 32'h1234;
    for (int i = 0; i < 3; i++) cycle("raw_stall", 1'b1);
    chk("raw.stalls3", {16'd0, o_stalls}, 32'd3);
    i_wb_en = 1'b1; i_wb_reg = 5'd5; i_wb_val = 32'hABCD;
    cycle("raw_wb", 1'b1);
    chk("raw_wb.fwd_issue", {31'd0, o_valid}, {31'd0, FWD});
    i_wb_en = 1'b0; i_reg0_val = 32'hABCD;
    cycle("raw_after", 1'b1);
    chk("raw_after.o_a", o_a, 32'hABCD);

    // Register 0 handling
    instr(5'd0, 5'd0, 5'd0, 1'b1);
    i_reg0_val = 32'hFFFF_FFFF; i_reg1_val = 32'hFFFF_FFFF;
    cycle("r0", 1'b1);
    chk("r0.o_a", o_a, 32'd0);
    instr(5'd0, 5'd0, 5'd4, 1'b0);
    cycle("r0_read", 1'b1);

    // Backpressure: hold output, then release
    instr(5'd1, 5'd2, 5'd0, 1'b0);
    i_ready = 1'b0;
    cycle("bp_load", 1'b1);
    instr(5'd2, 5'd1, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("bp_hold", 1'b1);
    i_ready = 1'b1;
    cycle("bp_rel", 1'b1);

    // Same-cycle set/clear on r7
    instr(5'd0, 5'd0, 5'd7, 1'b1);
    i_wb_en = 1'b1; i_wb_reg = 5'd7; i_wb_val = 32'h77;
    cycle("r7_setclr", 1'b1);
    i_wb_en = 1'b0;
    instr(5'd0, 5'd7, 5'd0, 1'b0);
    cycle("r7_stall", 1'b1);
    chk("r7.stalled", {31'd0, o_ready}, 32'd0);
    i_wb_en = 1'b1; i_wb_reg = 5'd7;
    cycle("r7_clear", 1'b1);
    i_wb_en = 1'b0;

    // Stall saturation on r9
    instr(5'd0, 5'd0, 5'd9, 1'b1);
    cycle("sat_w", 1'b1);
    instr(5'd9, 5'd9, 5'd0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle("sat", 1'b0);
    chk("sat.o_stalls", {16'd0, o_stalls}, 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) cycle("sat_hold", 1'b1);
    chk("sat_hold.o_stalls", {16'd0, o_stalls}, 32'h0000_FFFF);
    i_wb_en = 1'b1; i_wb_reg = 5'd9;
    cycle("sat_clear", 1'b1);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      i_valid = 1'($urandom_range(0, 3) != 0);
      i_op = 6'($urandom); i_imm = $urandom;
      i_rs0 = 5'($urandom_range(0, 7)); i_rs1 = 5'($urandom_range(0, 7));
      i_rd = 5'($urandom_range(0, 7)); i_rd_we = 1'($urandom);
      i_reg0_val = $urandom; i_reg1_val = $urandom;
      i_wb_en = 1'($urandom_range(0, 2) != 0);
      i_wb_reg = 5'($urandom_range(0, 7)); i_wb_val = $urandom;
      i_ready = 1'($urandom_range(0, 3) != 0);
      cycle("rand", 1'b1);
    end

    // Asynchronous reset mid-operation
    instr(5'd0, 5'd0, 5'd3, 1'b1);
    i_wb_en = 1'b0; i_ready = 1'b0;
    cycle("pre_rst", 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    chk("arst.o_valid", {31'd0, o_valid}, 32'd0);
    chk("arst.o_stalls", {16'd0, o_stalls}, 32'd0);
    check_regs("arst");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    instr(5'd3, 5'd0, 5'd0, 1'b0);
    i_ready = 1'b1;
    cycle("post_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/opfetch.md
# opfetch

Operand-fetch stage between instruction decode and execute. Accepts one decoded instruction per cycle over a valid/ready handshake and drives the register-file read indices. It captures both operand values into a one-entry output register for the execute stage. A 32-entry scoreboard tracks pending register writes and stalls on read-after-write hazards; writeback bypass is optional.

## Interface
- No parameters; data width fixed at 32, register index width at 5.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  decoded instruction present.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_op  in  6  opcode, passed through.
- i_rs0, i_rs1  in  5  source register indices.
- i_rd  in  5  destination index.
- i_rd_we  in  1  instruction writes i_rd.
- i_imm  in  32  immediate, passed through.
- o_reg0, o_reg1  out  5  register-file read indices; combinational copies of i_rs0, i_rs1.
- i_reg0_val, i_reg1_val  in  32  register-file read data, same cycle.
- i_wb_en  in  1  writeback commits this cycle.
- i_wb_reg  in  5  writeback index.
- i_wb_val  in  32  writeback value.
- o_valid  out  1  output register holds an instruction.
- i_ready  in  1  execute stage consumes the output this cycle.
- o_op (6), o_a (32), o_b (32), o_rd (5), o_rd_we (1), o_imm (32)  out  registered instruction fields and operands.
- o_stalls  out  16  saturating count of hazard-stall cycles.

## Operation
- Register 0 reads as 0 regardless of i_regN_val. It is never marked pending.
- Scoreboard: 32 pending bits, one per register.
- Hazard: i_valid, and rs0 or rs1 is nonzero, pending, and not bypassable.
- Bypassable (OPF_FWD_EN only): i_wb_en and i_wb_reg equals that source index.
- Operand select, per source: zero if index is 0; else i_wb_val if bypassed; else i_regN_val.
- o_ready = (!o_valid || i_ready) && !hazard.
- Issue = i_valid && o_ready. On issue:
  - output register loads op, rd, rd_we, imm and the selected operands;
  - o_valid is set;
  - pending[i_rd] is set if i_rd_we and i_rd != 0.
- Without issue: if i_ready && o_valid, o_valid clears; fields hold their last values.
- Writeback: i_wb_en clears pending[i_wb_reg].
- Same register issued and written back in one cycle: set wins, because the new writer is younger.
- o_stalls increments on every cycle with i_valid && hazard, and saturates at 16'hFFFF.

## Timing
- Reset values: o_valid=0; o_op, o_a, o_b, o_rd, o_imm all 0; o_rd_we=0; all pending bits 0; o_stalls=0.
- Reset mid-operation discards the held instruction and the scoreboard immediately (asynchronous).
- Latency: issue at edge N, o_valid high after edge N.
- Throughput: 1 instruction/cycle with no hazard and i_ready held high.
- o_ready and o_reg0/o_reg1 are combinational from inputs and state; no registered path from i_ready.
- With OPF_FWD_EN, a hazard clears in the same cycle i_wb_en writes the source.
- Without OPF_FWD_EN, the earliest issue is the cycle after writeback, when the register file holds the value.

## Configuration
- OPF_FWD_EN defined: writeback bypass into operand select and hazard check, as above.
- OPF_FWD_EN undefined: no bypass. Hazard is any nonzero pending source, and i_wb_val is unused.

## Test plan
- Reset with i_valid=1 asserted: o_valid=0, o_stalls=0, o_ready=1. After release, an instruction with rs0=3 (i_reg0_val=0x11) issues and o_a=0x11 next cycle.
- Back-to-back RAW: issue rd=5 we=1, then rs0=5 -> o_ready=0 and o_stalls increments each cycle. Writeback reg 5 = 0xABCD. With OPF_FWD_EN, issue that cycle with o_a=0xABCD; without it, issue one cycle later from i_reg0_val.
- Register 0: rs0=0 with i_reg0_val=0xFFFF_FFFF -> o_a=0. Issuing rd=0 we=1 never stalls a later read of r0.
- Backpressure: o_valid=1 and i_ready=0 -> o_ready=0, outputs stable for 4 cycles. Then i_ready=1 -> the next instruction issues that cycle.
- Simultaneous set and clear on r7: issue rd=7 while i_wb_en writes reg 7 -> pending[7] stays 1. A following rs1=7 stalls.
- Stall saturation: hold a hazard for 70000 cycles -> o_stalls=16'hFFFF and stays there.
